// File: rtl/present_pkg.sv
// Shared PRESENT-80 tables, layer/key-step functions and FSM encoding.
// Optional key cache in the core is enabled by PRESENT_DEC_KEYCACHE_EN.
package present_pkg;

    localparam int ROUNDS = 31;
    localparam int KEY_W  = 80;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_KEXP = 2'd1,
        S_DEC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] SBOX_INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    function automatic logic [63:0] p_layer_inv(
        input logic [63:0] s
    );
        logic [63:0] r;
        logic [5:0]  src;
        r[63] = s[63];
        for (int p = 0; p < 63; p++) begin
            src  = 6'((p * 16) % 63);
            r[p] = s[src];
        end
        return r;
    endfunction

    function automatic logic [63:0] sbox_layer_inv(
        input logic [63:0] s
    );
        logic [63:0] r;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = SBOX_INV[s[4*n +: 4]];
        end
        return r;
    endfunction

    function automatic logic [79:0] key_fwd_step(
        input logic [79:0] k,
        input logic [4:0]  i
    );
        logic [79:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = SBOX[t[79:76]];
        t[19:15]   = t[19:15] ^ i;
        return t;
    endfunction

    // Exact inverse of key_fwd_step: undo XOR, undo S, rotate back.
    function automatic logic [79:0] key_inv_step(
        input logic [79:0] k,
        input logic [4:0]  i
    );
        logic [79:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ i;
        t[79:76]   = SBOX_INV[t[79:76]];
        return {t[60:0], t[79:61]};
    endfunction

endpackage

// File: rtl/present_key_step.sv
// Combinational PRESENT-80 key schedule step.
// dir=0 runs the forward step, dir=1 the inverse step.
module present_key_step
    import present_pkg::*;
(
    input  logic        dir,
    input  logic [4:0]  rc,
    input  logic [79:0] kin,
    output logic [79:0] kout
);

    assign kout = dir ? key_inv_step(kin, rc)
                      : key_fwd_step(kin, rc);

endmodule

// File: rtl/present_dec_core.sv
// Iterative PRESENT-80 decryption core, one round per clock.
// Define PRESENT_DEC_KEYCACHE_EN to cache K32 for reuse_key requests.
module present_dec_core
    import present_pkg::*;
#(
    parameter int ROUNDS = 31,
    parameter int KEY_W  = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      ct,
    input  logic [KEY_W-1:0] keyin,
    input  logic             reuse_key,
    output logic             busy,
    output logic [63:0]      pt,
    output logic             pt_valid,
    input  logic             pt_ready
);

    state_t           state;
    logic [4:0]       kcnt;
    logic [4:0]       rnd;
    logic [63:0]      st;
    logic [KEY_W-1:0] key_reg;
    logic [KEY_W-1:0] kstep;
    logic [63:0]      dec_next;
    logic             kdir;
    logic [4:0]       krc;

    assign kdir = (state == S_DEC);
    assign krc  = kdir ? rnd : kcnt;

    present_key_step u_key_step (
        .dir  (kdir),
        .rc   (krc),
        .kin  (key_reg),
        .kout (kstep)
    );

    assign dec_next = sbox_layer_inv(p_layer_inv(st))
                    ^ kstep[79:16];

`ifdef PRESENT_DEC_KEYCACHE_EN
    logic [KEY_W-1:0] cache_k32;
    logic             cache_vld;
    logic             use_cache;

    assign use_cache = reuse_key && cache_vld;
`else
    logic unused_reuse;

    assign unused_reuse = reuse_key;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            pt_valid <= 1'b0;
            pt       <= '0;
            kcnt     <= '0;
            rnd      <= '0;
            st       <= '0;
            key_reg  <= '0;
`ifdef PRESENT_DEC_KEYCACHE_EN
            cache_k32 <= '0;
            cache_vld <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
`ifdef PRESENT_DEC_KEYCACHE_EN
                        if (use_cache) begin
                            st      <= ct ^ cache_k32[79:16];
                            key_reg <= cache_k32;
                            rnd     <= 5'(ROUNDS);
                            state   <= S_DEC;
                        end else begin
                            st      <= ct;
                            key_reg <= keyin;
                            kcnt    <= 5'd1;
                            state   <= S_KEXP;
                        end
`else
                        st      <= ct;
                        key_reg <= keyin;
                        kcnt    <= 5'd1;
                        state   <= S_KEXP;
`endif
                    end
                end
                S_KEXP: begin
                    key_reg <= kstep;
                    // st still holds the latched ciphertext here
                    if (kcnt == 5'(ROUNDS)) begin
                        st    <= st ^ kstep[79:16];
                        rnd   <= 5'(ROUNDS);
                        state <= S_DEC;
`ifdef PRESENT_DEC_KEYCACHE_EN
                        cache_k32 <= kstep;
                        cache_vld <= 1'b1;
`endif
                    end else begin
                        kcnt <= kcnt + 5'd1;
                    end
                end
                S_DEC: begin
                    key_reg <= kstep;
                    st      <= dec_next;
                    if (rnd == 5'd1) begin
                        pt       <= dec_next;
                        pt_valid <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        rnd <= rnd - 5'd1;
                    end
                end
                S_DONE: begin
                    if (pt_ready) begin
                        pt_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_present_dec_core.sv
// Scoreboard bench for present_dec_core; expected plaintexts come from
// a bench-side PRESENT-80 encryption model over random keys/plaintexts.
module tb_present_dec_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] ct_i = '0;
    logic [79:0] key_i = '0;
    logic        reuse_key = 1'b0;
    logic        busy;
    logic [63:0] pt;
    logic        pt_valid;
    logic        pt_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] pt;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    logic pv_q = 1'b0;

    present_dec_core dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ct        (ct_i),
        .keyin     (key_i),
        .reuse_key (reuse_key),
        .busy      (busy),
        .pt        (pt),
        .pt_valid  (pt_valid),
        .pt_ready  (pt_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

`ifdef PRESENT_DEC_KEYCACHE_EN
    localparam int REUSE_LAT = 31;
`else
    localparam int REUSE_LAT = 62;
`endif

    // Reference PRESENT-80 encryption: build all round keys, then rounds.
    function automatic logic [63:0] enc(
        input logic [63:0] p,
        input logic [79:0] key
    );
        int          sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13,
                                 3, 14, 15, 8, 4, 7, 1, 2};
        logic [63:0] rk [33];
        logic [79:0] kr;
        logic [63:0] s;
        logic [63:0] o;
        kr = key;
        for (int i = 1; i <= 32; i++) begin
            rk[i] = kr[79:16];
            kr = (kr << 61) | (kr >> 19);
            kr[79:76] = 4'(sb[kr[79:76]]);
            kr[19:15] = kr[19:15] ^ 5'(i);
        end
        s = p;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ rk[r];
            for (int n = 0; n < 16; n++)
                s[4*n +: 4] = 4'(sb[s[4*n +: 4]]);
            o = '0;
            for (int b = 0; b < 64; b++)
                o[(b == 63) ? 63 : (b * 16) % 63] = s[b];
            s = o;
        end
        return s ^ rk[32];
    endfunction

    function automatic logic [79:0] rand80();
        return {$urandom, $urandom, 16'($urandom)};
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Monitor: one comparison pair per new result.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (pt_valid && !pv_q) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result pt=%h", pt);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                checks++;
                if (pt !== e.pt) begin
                    errors++;
                    $display("FAIL pt got=%h exp=%h", pt, e.pt);
                end
                checks++;
                if (cyc - a != e.lat) begin
                    errors++;
                    $display("FAIL latency got=%0d exp=%0d",
                             cyc - a, e.lat);
                end
            end
        end
        pv_q <= pt_valid;
    end

    task automatic issue(
        input logic [63:0] c,
        input logic [79:0] k,
        input logic        ru,
        input logic [63:0] e,
        input int          lat
    );
        @(negedge clk);
        ct_i = c;
        key_i = k;
        reuse_key = ru;
        start = 1'b1;
        exp_q.push_back('{e, lat});
        @(posedge clk);
        #1;
        start = 1'b0;
        acc_q.push_back(cyc);
    endtask

    task automatic run(
        input logic [63:0] c,
        input logic [79:0] k,
        input logic        ru,
        input logic [63:0] e,
        input int          lat,
        input bit          hold,
        input bit          pulse
    );
        bit got = 0;
        issue(c, k, ru, e, lat);
        for (int n = 0; n < 150 && !got; n++) begin
            @(negedge clk);
            if (pt_valid) got = 1;
            else if (pulse && (n == 20 || n == 40)) begin
                start = 1'b1;
                ct_i = ~c;
            end else start = 1'b0;
        end
        start = 1'b0;
        if (!got) begin
            errors++;
            $display("FAIL timeout waiting for pt_valid");
            exp_q.delete();
            acc_q.delete();
            return;
        end
        if (hold) begin
            for (int h = 0; h < 10; h++) begin
                @(negedge clk);
                checks++;
                if (!(pt_valid && !busy && pt === e)) begin
                    errors++;
                    $display("FAIL hold v=%b busy=%b pt=%h exp=%h",
                             pt_valid, busy, pt, e);
                end
                start = (h == 4);
            end
            start = 1'b0;
        end
        pt_ready = 1'b1;
        @(posedge clk);
        #1;
        pt_ready = 1'b0;
        checks++;
        if (pt_valid !== 1'b0) begin
            errors++;
            $display("FAIL handshake pt_valid=%b exp=0", pt_valid);
        end
    endtask

    initial begin
        logic [79:0] k;
        logic [79:0] kx;
        logic [63:0] p;

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || pt_valid !== 1'b0 || pt !== '0) begin
            errors++;
            $display("FAIL reset_state busy=%b v=%b pt=%h exp=0/0/0",
                     busy, pt_valid, pt);
        end
        rst = 1'b0;

        run(64'h5579C1387B228445, '0, 0, 64'h0, 62, 0, 0);
        run(64'hE72C46C0F5945049, '1, 0, 64'h0, 62, 0, 0);
        run(64'hA112FFC72F68417B, '0, 0, '1, 62, 0, 0);
        run(64'h3333DCD3213210D2, '1, 0, '1, 62, 1, 1);

        // Abort mid-operation with reset.
        issue(64'h5579C1387B228445, '0, 0, 64'h0, 62);
        repeat (39) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        checks++;
        if (busy !== 1'b0 || pt_valid !== 1'b0 || pt !== '0) begin
            errors++;
            $display("FAIL mid_reset busy=%b v=%b pt=%h exp=0/0/0",
                     busy, pt_valid, pt);
        end
        run(64'hE72C46C0F5945049, '1, 0, 64'h0, 62, 0, 0);

        for (int t = 0; t < 8; t++) begin
            k = rand80();
            p = rand64();
            run(enc(p, k), k, 0, p, 62, 0, 0);
            p = rand64();
`ifdef PRESENT_DEC_KEYCACHE_EN
            kx = rand80();
`else
            kx = k;
`endif
            run(enc(p, k), kx, 1, p, REUSE_LAT, 0, 0);
        end

        // Reset clears any cached key: first reuse runs full flow.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run(64'h5579C1387B228445, '0, 1, 64'h0, 62, 0, 0);
        run(64'h5579C1387B228445, '0, 1, 64'h0, REUSE_LAT, 0, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results got=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
